// File: rtl/fp_addsub_pipe.sv
// Three-stage elastic floating-point adder/subtractor (align, add/sub, normalise/round/pack).
// Denormals flush to zero, rounding is round-to-nearest-even, and the tag rides with its operation.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 15,
  parameter int TAG_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  input  logic                 sub_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [EXP_W+MAN_W:0] result_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [3:0]           flags_o
);
  localparam int FW  = 1 + EXP_W + MAN_W;
  localparam int W   = MAN_W + 4;   // hidden, mantissa, guard, round, sticky
  localparam int SW  = EXP_W + 2;   // exponent workspace; MSB set means negative
  localparam int LZW = $clog2(W + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [FW-1:0]    QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
    lzc = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (v[i]) lzc = LZW'(W - 1 - i);
    end
  endfunction

  // Handshake chain: a stage may load when it is empty or its content leaves this cycle.
  logic v1_q, v2_q, v3_q;
  logic free1, free2, free3;
  assign free3   = !v3_q || ready_i;
  assign free2   = !v2_q || free3;
  assign free1   = !v1_q || free2;
  assign ready_o = free1;
  assign valid_o = v3_q;

  // S1 operand decode
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, a_big;
  logic [W-1:0]     ext_a, ext_b, ext_small;
  logic [EXP_W-1:0] exp_small, exp_diff, shamt;
  logic [2*W-1:0]   shift_wide;

  assign sign_a = a_i[FW-1];
  assign sign_b = b_i[FW-1] ^ sub_i;
  assign exp_a  = a_i[FW-2:MAN_W];
  assign exp_b  = b_i[FW-2:MAN_W];
  assign man_a  = a_i[MAN_W-1:0];
  assign man_b  = b_i[MAN_W-1:0];
  assign zero_a = (exp_a == {EXP_W{1'b0}});
  assign zero_b = (exp_b == {EXP_W{1'b0}});
  assign inf_a  = (exp_a == EXP_MAX) && (man_a == {MAN_W{1'b0}});
  assign inf_b  = (exp_b == EXP_MAX) && (man_b == {MAN_W{1'b0}});
  assign nan_a  = (exp_a == EXP_MAX) && (man_a != {MAN_W{1'b0}});
  assign nan_b  = (exp_b == EXP_MAX) && (man_b != {MAN_W{1'b0}});
  assign ext_a  = zero_a ? {W{1'b0}} : {1'b1, man_a, 3'b000};
  assign ext_b  = zero_b ? {W{1'b0}} : {1'b1, man_b, 3'b000};
  assign a_big  = {exp_a, ext_a} >= {exp_b, ext_b};

  logic             s1_sign_d, s1_sub_d, s1_spec_d, s1_inv_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [W-1:0]     s1_big_d, s1_small_d;
  logic [FW-1:0]    s1_spec_res_d;
  logic             s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [W-1:0]     s1_big_q, s1_small_q;
  logic [FW-1:0]    s1_spec_res_q;
  logic [TAG_W-1:0] s1_tag_q;

  // S1: order by magnitude, align the smaller operand with sticky, resolve special operands
  always_comb begin
    s1_sign_d  = a_big ? sign_a : sign_b;
    s1_exp_d   = a_big ? exp_a : exp_b;
    s1_big_d   = a_big ? ext_a : ext_b;
    ext_small  = a_big ? ext_b : ext_a;
    exp_small  = a_big ? exp_b : exp_a;
    exp_diff   = s1_exp_d - exp_small;
    shamt      = (exp_diff > EXP_W'(W - 1)) ? EXP_W'(W - 1) : exp_diff;
    shift_wide = {ext_small, {W{1'b0}}} >> shamt;
    s1_small_d = {shift_wide[2*W-1:W+1], shift_wide[W] | (|shift_wide[W-1:0])};
    s1_sub_d   = sign_a ^ sign_b;
    s1_spec_d     = 1'b1;
    s1_inv_d      = 1'b0;
    s1_spec_res_d = QNAN;
    if (nan_a || nan_b) begin
      s1_inv_d = (nan_a && !man_a[MAN_W-1]) || (nan_b && !man_b[MAN_W-1]);
    end else if (inf_a && inf_b && s1_sub_d) begin
      s1_inv_d = 1'b1;
    end else if (inf_a) begin
      s1_spec_res_d = {sign_a, EXP_MAX, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      s1_spec_res_d = {sign_b, EXP_MAX, {MAN_W{1'b0}}};
    end else if (zero_a && zero_b) begin
      s1_spec_res_d = {sign_a & sign_b, {(FW-1){1'b0}}};
    end else begin
      s1_spec_d     = 1'b0;
      s1_spec_res_d = {FW{1'b0}};
    end
  end

  // S1 register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q          <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_inv_q      <= 1'b0;
      s1_exp_q      <= {EXP_W{1'b0}};
      s1_big_q      <= {W{1'b0}};
      s1_small_q    <= {W{1'b0}};
      s1_spec_res_q <= {FW{1'b0}};
      s1_tag_q      <= {TAG_W{1'b0}};
    end else if (free1) begin
      v1_q <= valid_i;
      if (valid_i) begin
        s1_sign_q     <= s1_sign_d;
        s1_sub_q      <= s1_sub_d;
        s1_spec_q     <= s1_spec_d;
        s1_inv_q      <= s1_inv_d;
        s1_exp_q      <= s1_exp_d;
        s1_big_q      <= s1_big_d;
        s1_small_q    <= s1_small_d;
        s1_spec_res_q <= s1_spec_res_d;
        s1_tag_q      <= tag_i;
      end
    end
  end

  // S2: magnitude add or subtract; big >= small so the difference never goes negative
  logic [W:0]       s2_sum_d, s2_sum_q;
  logic             s2_sign_q, s2_spec_q, s2_inv_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [FW-1:0]    s2_spec_res_q;
  logic [TAG_W-1:0] s2_tag_q;

  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                             : ({1'b0, s1_big_q} + {1'b0, s1_small_q});

  // S2 register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2_q          <= 1'b0;
      s2_sum_q      <= {(W+1){1'b0}};
      s2_sign_q     <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_exp_q      <= {EXP_W{1'b0}};
      s2_spec_res_q <= {FW{1'b0}};
      s2_tag_q      <= {TAG_W{1'b0}};
    end else if (free2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_sum_q      <= s2_sum_d;
        s2_sign_q     <= s1_sign_q;
        s2_spec_q     <= s1_spec_q;
        s2_inv_q      <= s1_inv_q;
        s2_exp_q      <= s1_exp_q;
        s2_spec_res_q <= s1_spec_res_q;
        s2_tag_q      <= s1_tag_q;
      end
    end
  end

  // S3 datapath
  logic [LZW-1:0]   lz;
  logic [W-1:0]     norm;
  logic [SW-1:0]    nexp, fexp;
  logic             round_up, inexact;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] fman;
  logic [FW-1:0]    res_d, res_q;
  logic [3:0]       flags_d, flags_q;
  logic [TAG_W-1:0] tag_q;

  // S3: normalise, round to nearest even, then pick special/zero/underflow/overflow/normal result
  always_comb begin
    lz = lzc(s2_sum_q[W-1:0]);
    if (s2_sum_q[W]) begin
      norm = {s2_sum_q[W:2], s2_sum_q[1] | s2_sum_q[0]};
      nexp = {2'b00, s2_exp_q} + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      norm = s2_sum_q[W-1:0] << lz;
      nexp = {2'b00, s2_exp_q} - {{(SW-LZW){1'b0}}, lz};
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact  = |norm[2:0];
    rnd      = {1'b0, norm[W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (rnd[MAN_W+1]) begin
      fexp = nexp + {{(SW-1){1'b0}}, 1'b1};
      fman = rnd[MAN_W:1];
    end else begin
      fexp = nexp;
      fman = rnd[MAN_W-1:0];
    end
    if (s2_spec_q) begin
      res_d   = s2_spec_res_q;
      flags_d = {s2_inv_q, 3'b000};
    end else if (s2_sum_q == {(W+1){1'b0}}) begin
      res_d   = {FW{1'b0}};
      flags_d = 4'b0000;
    end else if (nexp[SW-1] || (nexp == {SW{1'b0}})) begin
      res_d   = {s2_sign_q, {(FW-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (fexp >= {2'b00, EXP_MAX}) begin
      res_d   = {s2_sign_q, EXP_MAX, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else begin
      res_d   = {s2_sign_q, fexp[EXP_W-1:0], fman};
      flags_d = {3'b000, inexact};
    end
  end

  // S3 register drives the outputs directly and holds them while downstream stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v3_q    <= 1'b0;
      res_q   <= {FW{1'b0}};
      flags_q <= 4'b0000;
      tag_q   <= {TAG_W{1'b0}};
    end else if (free3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        res_q   <= res_d;
        flags_q <= flags_d;
        tag_q   <= s2_tag_q;
      end
    end
  end

  assign result_o = res_q;
  assign flags_o  = flags_q;
  assign tag_o    = tag_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors push expectations, a negedge monitor compares.
module tb_fp_addsub_pipe;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_o, sub_i, valid_o, ready_i;
  logic [23:0] a_i, b_i, result_o;
  logic [3:0]  tag_i, tag_o, flags_o;

  logic        toggle_en, rdy_hold;
  logic [3:0]  pat_v = 4'b1001;
  int          ph = 0;
  int          checks = 0;
  int          errors = 0;
  int          inflight = 0;
  logic        exp_ready;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;
  assign ready_i = toggle_en ? pat_v[ph] : rdy_hold;

  fp_addsub_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .tag_o(tag_o), .flags_o(flags_o)
  );

  // downstream ready pattern 1,0,0,1 advances just after each rising edge
  always @(posedge clk_i) begin
    #1;
    ph = (ph + 1) % 4;
  end

  // monitor: ready_o against occupancy model, outputs against scoreboard head
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      inflight = 0;
    end else begin
      exp_ready = !(inflight == 3 && !ready_i);
      checks++;
      if (ready_o !== exp_ready) begin
        errors++;
        $display("FAIL ready_o t=%0t: got %b expected %b (inflight %0d ready_i %b)",
                 $time, ready_o, exp_ready, inflight, ready_i);
      end
      if (valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result t=%0t: got res=%h tag=%h, expected no result",
                   $time, result_o, tag_o);
        end else begin
          if ({result_o, flags_o, tag_o} !== exp_q[0]) begin
            errors++;
            $display("FAIL result t=%0t: got res=%h flags=%b tag=%h, expected res=%h flags=%b tag=%h",
                     $time, result_o, flags_o, tag_o, exp_q[0][31:8], exp_q[0][7:4], exp_q[0][3:0]);
          end
          if (ready_i) void'(exp_q.pop_front());
        end
      end
      inflight = inflight + ((valid_i && exp_ready) ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
    end
  end

  // called one time unit after a rising edge; returns one time unit after the accepting edge
  task automatic send(input logic [23:0] a, input logic [23:0] b, input logic s,
                      input logic [3:0] t, input logic [23:0] er, input logic [3:0] ef);
    int n;
    a_i = a; b_i = b; sub_i = s; tag_i = t; valid_i = 1'b1;
    n = 0;
    #3;
    while (!ready_o && n < 100) begin
      @(posedge clk_i);
      #4;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%h: got ready_o=0 for %0d cycles, expected 1", t, n);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
    end else begin
      exp_q.push_back({er, ef, t});
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by t=%0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; sub_i = 1'b0; a_i = 24'h0; b_i = 24'h0; tag_i = 4'h0;
    toggle_en = 1'b0; rdy_hold = 1'b1;
    #12;
    checks++;
    if ({valid_o, result_o, tag_o, flags_o} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h tag=%h flags=%b, expected all 0",
               valid_o, result_o, tag_o, flags_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", ready_o);
    end
    @(posedge clk_i);
    #1;

    // 1.0 + 1.0 and its latency
    send(24'h3F8000, 24'h3F8000, 1'b0, 4'h5, 24'h400000, 4'b0000);
    #13;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got valid_o=%b two cycles after accept, expected 0", valid_o);
    end
    #10;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_3: got valid_o=%b three cycles after accept, expected 1", valid_o);
    end
    drain();

    // directed vectors, ready_i held high, issued back-to-back
    send(24'h3FC000, 24'h3FC000, 1'b1, 4'h1, 24'h000000, 4'b0000);
    send(24'h3F8000, 24'h378000, 1'b0, 4'h2, 24'h3F8000, 4'b0001);
    send(24'h3F8001, 24'h378000, 1'b0, 4'h3, 24'h3F8002, 4'b0001);
    send(24'h7F7FFF, 24'h7F7FFF, 1'b0, 4'h4, 24'h7F8000, 4'b0101);
    send(24'h7F8000, 24'h7F8000, 1'b1, 4'h6, 24'h7FC000, 4'b1000);
    send(24'h000001, 24'h3F8000, 1'b0, 4'h7, 24'h3F8000, 4'b0000);
    send(24'h008000, 24'h00C000, 1'b1, 4'h8, 24'h800000, 4'b0011);
    send(24'h3F8000, 24'h400000, 1'b1, 4'h9, 24'hBF8000, 4'b0000);
    send(24'h7FC001, 24'h3F8000, 1'b0, 4'hA, 24'h7FC000, 4'b0000);
    send(24'h7F8001, 24'h3F8000, 1'b0, 4'hB, 24'h7FC000, 4'b1000);
    send(24'h7F8000, 24'h3F8000, 1'b1, 4'hC, 24'h7F8000, 4'b0000);
    send(24'h800000, 24'h800000, 1'b0, 4'hD, 24'h800000, 4'b0000);
    send(24'h3F8000, 24'h2B8000, 1'b0, 4'hE, 24'h3F8000, 4'b0001);
    send(24'h3FFFFF, 24'h378000, 1'b0, 4'hF, 24'h400000, 4'b0001);
    drain();

    // 8 back-to-back ops under a stalling downstream: x+x on even k, x-x/2 on odd k
    toggle_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        send({1'b0, 8'(127 + k), 15'h0}, {1'b0, 8'(127 + k), 15'h0}, 1'b0, 4'(k + 1),
             {1'b0, 8'(128 + k), 15'h0}, 4'b0000);
      else
        send({1'b0, 8'(127 + k), 15'h0}, {1'b0, 8'(126 + k), 15'h0}, 1'b1, 4'(k + 1),
             {1'b0, 8'(126 + k), 15'h0}, 4'b0000);
    end
    drain();
    toggle_en = 1'b0;

    // reset with three ops in flight and downstream stalled
    rdy_hold = 1'b0;
    send(24'h3F8000, 24'h3F8000, 1'b0, 4'h1, 24'h400000, 4'b0000);
    send(24'h3F8000, 24'h3F8000, 1'b0, 4'h2, 24'h400000, 4'b0000);
    send(24'h3F8000, 24'h3F8000, 1'b0, 4'h3, 24'h400000, 4'b0000);
    #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({valid_o, result_o, tag_o, flags_o} !== 33'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b res=%h tag=%h flags=%b, expected all 0",
               valid_o, result_o, tag_o, flags_o);
    end
    exp_q.delete();
    rdy_hold = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    send(24'h3F8000, 24'h400000, 1'b0, 4'h6, 24'h404000, 4'b0000);
    drain();
    repeat (4) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
